// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_decode
// Purpose  : MIPS-I instruction decoder for ALU control, registered as the
//            ID/EX pipeline stage. Supports stall and flush, and keeps a
//            saturating count of illegal instructions.
// Revision : 1.0
// ============================================================================
module alu_ctrl_decode #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [3:0]       ex_aluc,
    output logic [1:0]       ex_asel,
    output logic             ex_bsel,
    output logic             ex_imm_zext,
    output logic             ex_of_trap,
    output logic             ex_illegal,
    output logic [31:0]      ex_instr,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0001;
    localparam logic [3:0] c_ALU_OR  = 4'b0010;
    localparam logic [3:0] c_ALU_AND = 4'b0011;
    localparam logic [3:0] c_ALU_SLL = 4'b0100;
    localparam logic [3:0] c_ALU_SRL = 4'b0101;
    localparam logic [3:0] c_ALU_SRA = 4'b0110;
    localparam logic [3:0] c_ALU_XOR = 4'b0111;
    localparam logic [3:0] c_ALU_NOR = 4'b1000;

    localparam logic [1:0] c_ASEL_RS    = 2'b00;
    localparam logic [1:0] c_ASEL_SHAMT = 2'b01;
    localparam logic [1:0] c_ASEL_C16   = 2'b10;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_dec_illegal;
    logic [3:0] w_dec_aluc;
    logic [1:0] w_dec_asel;
    logic       w_dec_bsel;
    logic       w_dec_zext;
    logic       w_dec_trap;

    assign w_op    = id_instr[31:26];
    assign w_funct = id_instr[5:0];

    always_comb begin
        w_dec_illegal = 1'b0;
        w_dec_aluc    = c_ALU_ADD;
        w_dec_asel    = c_ASEL_RS;
        w_dec_bsel    = 1'b0;
        w_dec_zext    = 1'b0;
        w_dec_trap    = 1'b0;
        if (w_op == 6'h00) begin
            unique case (w_funct)
                6'h20: begin w_dec_aluc = c_ALU_ADD; w_dec_trap = 1'b1; end
                6'h21: w_dec_aluc = c_ALU_ADD;
                6'h22: begin w_dec_aluc = c_ALU_SUB; w_dec_trap = 1'b1; end
                6'h23: w_dec_aluc = c_ALU_SUB;
                6'h24: w_dec_aluc = c_ALU_AND;
                6'h25: w_dec_aluc = c_ALU_OR;
                6'h26: w_dec_aluc = c_ALU_XOR;
                6'h27: w_dec_aluc = c_ALU_NOR;
                6'h00: begin w_dec_aluc = c_ALU_SLL; w_dec_asel = c_ASEL_SHAMT; end
                6'h02: begin w_dec_aluc = c_ALU_SRL; w_dec_asel = c_ASEL_SHAMT; end
                6'h03: begin w_dec_aluc = c_ALU_SRA; w_dec_asel = c_ASEL_SHAMT; end
                // Variable shifts take the amount from rs; ALU uses A[4:0].
                6'h04: w_dec_aluc = c_ALU_SLL;
                6'h06: w_dec_aluc = c_ALU_SRL;
                6'h07: w_dec_aluc = c_ALU_SRA;
                default: w_dec_illegal = 1'b1;
            endcase
        end else begin
            unique case (w_op)
                6'h08: begin w_dec_aluc = c_ALU_ADD; w_dec_bsel = 1'b1; w_dec_trap = 1'b1; end
                6'h09: begin w_dec_aluc = c_ALU_ADD; w_dec_bsel = 1'b1; end
                6'h0C: begin w_dec_aluc = c_ALU_AND; w_dec_bsel = 1'b1; w_dec_zext = 1'b1; end
                6'h0D: begin w_dec_aluc = c_ALU_OR;  w_dec_bsel = 1'b1; w_dec_zext = 1'b1; end
                6'h0E: begin w_dec_aluc = c_ALU_XOR; w_dec_bsel = 1'b1; w_dec_zext = 1'b1; end
                6'h0F: begin
                    w_dec_aluc = c_ALU_SLL;
                    w_dec_asel = c_ASEL_C16;
                    w_dec_bsel = 1'b1;
                    w_dec_zext = 1'b1;
                end
                6'h23, 6'h2B: begin w_dec_aluc = c_ALU_ADD; w_dec_bsel = 1'b1; end
                // Branches compare rs-rt; EX branches on the ALU zero flag.
                6'h04, 6'h05: w_dec_aluc = c_ALU_SUB;
                default: w_dec_illegal = 1'b1;
            endcase
        end
        if (w_dec_illegal) begin
            w_dec_aluc = c_ALU_ADD;
            w_dec_asel = c_ASEL_RS;
            w_dec_bsel = 1'b0;
            w_dec_zext = 1'b0;
            w_dec_trap = 1'b0;
        end
    end

    logic             ex_valid_q,   ex_valid_d;
    logic [3:0]       ex_aluc_q,    ex_aluc_d;
    logic [1:0]       ex_asel_q,    ex_asel_d;
    logic             ex_bsel_q,    ex_bsel_d;
    logic             ex_zext_q,    ex_zext_d;
    logic             ex_trap_q,    ex_trap_d;
    logic             ex_illegal_q, ex_illegal_d;
    logic [31:0]      ex_instr_q,   ex_instr_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_aluc_d    = ex_aluc_q;
        ex_asel_d    = ex_asel_q;
        ex_bsel_d    = ex_bsel_q;
        ex_zext_d    = ex_zext_q;
        ex_trap_d    = ex_trap_q;
        ex_illegal_d = ex_illegal_q;
        ex_instr_d   = ex_instr_q;
        cnt_d        = cnt_q;
        if (flush) begin
            ex_valid_d   = 1'b0;
            ex_aluc_d    = 4'd0;
            ex_asel_d    = 2'd0;
            ex_bsel_d    = 1'b0;
            ex_zext_d    = 1'b0;
            ex_trap_d    = 1'b0;
            ex_illegal_d = 1'b0;
            ex_instr_d   = 32'd0;
        end else if (!stall) begin
            // Invalid slots load as bubbles so trap/illegal never appear without ex_valid.
            ex_valid_d   = id_valid;
            ex_aluc_d    = id_valid ? w_dec_aluc : 4'd0;
            ex_asel_d    = id_valid ? w_dec_asel : 2'd0;
            ex_bsel_d    = id_valid & w_dec_bsel;
            ex_zext_d    = id_valid & w_dec_zext;
            ex_trap_d    = id_valid & w_dec_trap;
            ex_illegal_d = id_valid & w_dec_illegal;
            ex_instr_d   = id_instr;
            if (id_valid && w_dec_illegal && (cnt_q != c_CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_aluc_q    <= 4'd0;
            ex_asel_q    <= 2'd0;
            ex_bsel_q    <= 1'b0;
            ex_zext_q    <= 1'b0;
            ex_trap_q    <= 1'b0;
            ex_illegal_q <= 1'b0;
            ex_instr_q   <= 32'd0;
            cnt_q        <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_aluc_q    <= ex_aluc_d;
            ex_asel_q    <= ex_asel_d;
            ex_bsel_q    <= ex_bsel_d;
            ex_zext_q    <= ex_zext_d;
            ex_trap_q    <= ex_trap_d;
            ex_illegal_q <= ex_illegal_d;
            ex_instr_q   <= ex_instr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_aluc     = ex_aluc_q;
    assign ex_asel     = ex_asel_q;
    assign ex_bsel     = ex_bsel_q;
    assign ex_imm_zext = ex_zext_q;
    assign ex_of_trap  = ex_trap_q;
    assign ex_illegal  = ex_illegal_q;
    assign ex_instr    = ex_instr_q;
    assign illegal_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_decode
// Purpose  : Self-checking bench: directed decode/stall/flush/illegal/reset
//            steps followed by random traffic against a table-driven model.
// Revision : 1.0
// ============================================================================
module tb_alu_ctrl_decode;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_instr = 32'd0;
    logic        id_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        ex_valid, ex_bsel, ex_imm_zext, ex_of_trap, ex_illegal;
    logic [3:0]  ex_aluc;
    logic [1:0]  ex_asel;
    logic [31:0] ex_instr;
    logic [7:0]  illegal_cnt;

    logic        s_valid, s_bsel, s_zext, s_trap, s_illegal;
    logic [3:0]  s_aluc;
    logic [1:0]  s_asel;
    logic [31:0] s_instr;
    logic [1:0]  s_cnt;

    alu_ctrl_decode #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_aluc(ex_aluc),
        .ex_asel(ex_asel), .ex_bsel(ex_bsel), .ex_imm_zext(ex_imm_zext),
        .ex_of_trap(ex_of_trap), .ex_illegal(ex_illegal), .ex_instr(ex_instr),
        .illegal_cnt(illegal_cnt)
    );

    alu_ctrl_decode #(.CNT_W(2)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .stall(stall), .flush(flush), .ex_valid(s_valid), .ex_aluc(s_aluc),
        .ex_asel(s_asel), .ex_bsel(s_bsel), .ex_imm_zext(s_zext),
        .ex_of_trap(s_trap), .ex_illegal(s_illegal), .ex_instr(s_instr),
        .illegal_cnt(s_cnt)
    );

    always #5 if (clk_en) clk = ~clk;

    typedef struct packed {
        logic       ill;
        logic [3:0] aluc;
        logic [1:0] asel;
        logic       bsel;
        logic       zext;
        logic       trap;
    } ctl_t;

    localparam ctl_t c_ILL = '{ill: 1'b1, aluc: 4'd0, asel: 2'd0, bsel: 1'b0, zext: 1'b0, trap: 1'b0};

    ctl_t rtab [64];
    ctl_t itab [64];

    ctl_t        m_ctl;
    logic        m_valid;
    logic [31:0] m_instr;
    logic        m_instr_known;
    int          m_cnt8, m_cnt2;
    int          total = 0;
    int          bad = 0;

    function automatic ctl_t mk(input logic [3:0] a, input logic [1:0] s,
                                input logic b, input logic z, input logic t);
        mk = '{ill: 1'b0, aluc: a, asel: s, bsel: b, zext: z, trap: t};
    endfunction

    function automatic ctl_t ref_decode(input logic [31:0] ins);
        ref_decode = (ins[31:26] == 6'd0) ? rtab[ins[5:0]] : itab[ins[31:26]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctl = '0; m_valid = 1'b0; m_instr = 32'd0; m_instr_known = 1'b1;
        m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_clock();
        ctl_t d;
        if (flush) begin
            m_ctl = '0; m_valid = 1'b0; m_instr = 32'd0; m_instr_known = 1'b1;
        end else if (!stall) begin
            d = ref_decode(id_instr);
            m_valid = id_valid;
            m_ctl = id_valid ? d : '0;
            m_instr = id_instr;
            m_instr_known = id_valid;
            if (id_valid && d.ill) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    endtask

    task automatic check_all();
        chk("valid",   32'(ex_valid),    32'(m_valid));
        chk("aluc",    32'(ex_aluc),     32'(m_ctl.aluc));
        chk("asel",    32'(ex_asel),     32'(m_ctl.asel));
        chk("bsel",    32'(ex_bsel),     32'(m_ctl.bsel));
        chk("zext",    32'(ex_imm_zext), 32'(m_ctl.zext));
        chk("trap",    32'(ex_of_trap),  32'(m_ctl.trap));
        chk("illegal", 32'(ex_illegal),  32'(m_ctl.ill));
        if (m_instr_known) chk("instr", ex_instr, m_instr);
        chk("cnt8",    32'(illegal_cnt), 32'(m_cnt8));
        chk("cnt2",    32'(s_cnt),       32'(m_cnt2));
        chk("small_aluc", 32'(s_aluc),   32'(m_ctl.aluc));
        chk("invariant", 32'((ex_of_trap | ex_illegal) & ~ex_valid), 32'd0);
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic st, input logic fl);
        id_valid = v; id_instr = ins; stall = st; flush = fl;
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};
    logic [5:0] op_pool [15] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D,
                                 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h0A};
    logic [5:0] fn_pool [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h2A, 6'h18};

    initial begin
        for (int i = 0; i < 64; i++) begin
            rtab[i] = c_ILL;
            itab[i] = c_ILL;
        end
        // Reference table written from the instruction list (aluc, asel, bsel, zext, trap).
        rtab[6'h20] = mk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b1);
        rtab[6'h21] = mk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        rtab[6'h22] = mk(4'b0001, 2'b00, 1'b0, 1'b0, 1'b1);
        rtab[6'h23] = mk(4'b0001, 2'b00, 1'b0, 1'b0, 1'b0);
        rtab[6'h24] = mk(4'b0011, 2'b00, 1'b0, 1'b0, 1'b0);
        rtab[6'h25] = mk(4'b0010, 2'b00, 1'b0, 1'b0, 1'b0);
        rtab[6'h26] = mk(4'b0111, 2'b00, 1'b0, 1'b0, 1'b0);
        rtab[6'h27] = mk(4'b1000, 2'b00, 1'b0, 1'b0, 1'b0);
        rtab[6'h00] = mk(4'b0100, 2'b01, 1'b0, 1'b0, 1'b0);
        rtab[6'h02] = mk(4'b0101, 2'b01, 1'b0, 1'b0, 1'b0);
        rtab[6'h03] = mk(4'b0110, 2'b01, 1'b0, 1'b0, 1'b0);
        rtab[6'h04] = mk(4'b0100, 2'b00, 1'b0, 1'b0, 1'b0);
        rtab[6'h06] = mk(4'b0101, 2'b00, 1'b0, 1'b0, 1'b0);
        rtab[6'h07] = mk(4'b0110, 2'b00, 1'b0, 1'b0, 1'b0);
        itab[6'h08] = mk(4'b0000, 2'b00, 1'b1, 1'b0, 1'b1);
        itab[6'h09] = mk(4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
        itab[6'h0C] = mk(4'b0011, 2'b00, 1'b1, 1'b1, 1'b0);
        itab[6'h0D] = mk(4'b0010, 2'b00, 1'b1, 1'b1, 1'b0);
        itab[6'h0E] = mk(4'b0111, 2'b00, 1'b1, 1'b1, 1'b0);
        itab[6'h0F] = mk(4'b0100, 2'b10, 1'b1, 1'b1, 1'b0);
        itab[6'h23] = mk(4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
        itab[6'h2B] = mk(4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
        itab[6'h04] = mk(4'b0001, 2'b00, 1'b0, 1'b0, 1'b0);
        itab[6'h05] = mk(4'b0001, 2'b00, 1'b0, 1'b0, 1'b0);

        // Reset with the clock stopped.
        model_reset();
        #3;
        check_all();
        rst_n = 1'b1;
        #2;
        clk_en = 1'b1;
        step(1'b0, 32'h014B4820, 1'b0, 1'b0);
        step(1'b0, 32'h014B4820, 1'b0, 1'b0);
        chk("idle_valid", 32'(ex_valid), 32'd0);

        // Decode sweep.
        step(1'b1, 32'h014B4820, 1'b0, 1'b0);
        chk("add_trap", 32'(ex_of_trap), 32'd1);
        step(1'b1, 32'h3C01ABCD, 1'b0, 1'b0);
        chk("lui_aluc", 32'(ex_aluc), 32'b0100);
        chk("lui_asel", 32'(ex_asel), 32'b10);
        step(1'b1, 32'h00021080, 1'b0, 1'b0);
        chk("sll_asel", 32'(ex_asel), 32'b01);
        step(1'b1, 32'h8C220004, 1'b0, 1'b0);
        chk("lw_bsel", 32'(ex_bsel), 32'd1);
        step(1'b1, 32'h00000000, 1'b0, 1'b0);
        chk("nop_legal", 32'(ex_illegal), 32'd0);

        // Stall holds, flush wins over stall.
        step(1'b1, 32'h014B4822, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h3C01ABCD, 1'b1, 1'b0);
        chk("stall_hold_aluc", 32'(ex_aluc), 32'b0001);
        step(1'b1, 32'h3C01ABCD, 1'b1, 1'b1);
        chk("flush_valid", 32'(ex_valid), 32'd0);

        // Illegal counting.
        step(1'b1, 32'h012A402A, 1'b0, 1'b0);
        chk("slt_illegal", 32'(ex_illegal), 32'd1);
        chk("slt_cnt", 32'(illegal_cnt), 32'd1);
        step(1'b1, 32'h012A402A, 1'b1, 1'b0);
        chk("slt_stall_cnt", 32'(illegal_cnt), 32'd1);

        // Asynchronous reset while the clock runs.
        step(1'b1, 32'h014B4820, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Saturation on the narrow counter.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h0000000C, 1'b0, 1'b0);
            chk("sat_cnt2", 32'(s_cnt), 32'(sat_exp[i]));
        end

        // Random traffic.
        for (int n = 0; n < 10000; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                ins[31:26] = op_pool[$urandom_range(0, 14)];
                if (ins[31:26] == 6'h00) ins[5:0] = fn_pool[$urandom_range(0, 15)];
            end
            step($urandom_range(0, 9) != 0, ins,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
